button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The block SHALL have parameter BUTTON_COUNT, default 16: number of button lines, range 1..16.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 252000: consecutive stable cycles required to accept a level change (about 10 ms at 25.2 MHz), minimum 1.
REQ-003 The block SHALL have port system_clk, input, 1 bit: system clock, 25.2 MHz; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port buttons_in, input, BUTTON_COUNT bits: raw asynchronous controller lines, active-high.
REQ-006 The block SHALL have port frame_ack, input, 1 bit: one-cycle pulse (driven by copy_start); consumes the accumulated events.
REQ-007 The block SHALL have port buttons_stable, output, BUTTON_COUNT bits: debounced level per button.
REQ-008 The block SHALL have port pressed_events, output, BUTTON_COUNT bits: sticky flags for 0->1 transitions of buttons_stable since the last frame_ack.
REQ-009 The block SHALL have port released_events, output, BUTTON_COUNT bits: sticky flags for 1->0 transitions of buttons_stable since the last frame_ack.
REQ-010 The block SHALL have port any_event, output, 1 bit: OR-reduction of pressed_events and released_events, registered.

Function
REQ-011 Each buttons_in bit SHALL pass a 2-flop synchronizer (sync1, sync2) before any other use; no raw input reaches other logic.
REQ-012 Each button SHALL have an independent counter of width clog2(DEBOUNCE_CYCLES), minimum 1 bit.
REQ-013 In any cycle where sync2 == buttons_stable for a bit, that bit's counter SHALL load 0.
REQ-014 In any cycle where sync2 != buttons_stable and the counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-015 In any cycle where sync2 != buttons_stable and the counter == DEBOUNCE_CYCLES-1, buttons_stable SHALL load sync2 and the counter SHALL load 0.
REQ-016 The counter SHALL never wrap.
REQ-017 Latency: an input level held constant from before edge 0 SHALL appear on buttons_stable at edge 2+DEBOUNCE_CYCLES, exactly.
REQ-018 Glitch rejection: a changed input level lasting fewer than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change buttons_stable, and its counter SHALL return to 0.
REQ-019 A rise of a buttons_stable bit (REQ-015 with sync2 = 1) SHALL set the matching pressed_events bit at the same edge.
REQ-020 A fall of a buttons_stable bit SHALL set the matching released_events bit at the same edge.
REQ-021 On frame_ack = 1, pressed_events SHALL load the rise vector of that same cycle, and released_events SHALL load the fall vector of that same cycle; all other bits clear.
REQ-022 Rise and fall transitions coincident with frame_ack SHALL NOT be lost.
REQ-023 Without frame_ack, event bits SHALL only set (OR-accumulate), never clear.
REQ-024 A press and a release of the same button within one ack interval SHALL leave both pressed_events and released_events set.
REQ-025 any_event SHALL equal |(pressed_events | released_events) as registered one cycle after those flags.
REQ-026 frame_ack held high for multiple cycles SHALL behave as repeated acks, with no other side effects.
REQ-027 Bits are fully independent: simultaneous transitions on all BUTTON_COUNT lines SHALL each follow REQ-013..REQ-024 with identical timing.

Reset
REQ-028 While reset = 1, the block SHALL clear sync1, sync2, all counters, buttons_stable, pressed_events, released_events and any_event to 0 at each edge.
REQ-029 Reset SHALL override frame_ack and any in-progress debounce.
REQ-030 After reset deasserts, a line held high SHALL reach buttons_stable at edge 2+DEBOUNCE_CYCLES counted from the first non-reset edge, and SHALL set pressed_events at that edge.

Verification (DEBOUNCE_CYCLES = 4)
REQ-031 Press: buttons_in 0x0000->0x0001 before edge 0 -> buttons_stable = 0x0001 and pressed_events = 0x0001 at edge 6, not at edge 5; any_event = 1 at edge 7.
REQ-032 Glitch: bit 3 high for 3 cycles, then low -> buttons_stable, pressed_events and released_events remain 0x0000 throughout.
REQ-033 Ack ordering: with pressed_events = 0x0001 and bit 1 rising in the frame_ack cycle -> pressed_events = 0x0002 after the ack edge.
REQ-034 Release: bit 0 stable high, then falls -> released_events = 0x0001 at fall+6; a pulse 8 cycles long yields pressed = released = 0x0001.
REQ-035 Reset mid-debounce: assert reset while counter = 2 with input held high -> all outputs 0; buttons_stable rises exactly 6 edges after reset release.
REQ-036 All 16 lines going 0x0000->0xFFFF in one cycle -> buttons_stable = 0xFFFF and pressed_events = 0xFFFF at edge 6.

Source files
------------

// File: rtl/button_debouncer_if.sv
// Connection bundle between the debouncer and its consumer: raw button lines and
// frame acknowledge in, debounced levels and sticky edge events out.
interface button_debouncer_if #(
    parameter int BUTTON_COUNT = 16
) ();
    logic [BUTTON_COUNT-1:0] buttons_in;
    logic                    frame_ack;
    logic [BUTTON_COUNT-1:0] buttons_stable;
    logic [BUTTON_COUNT-1:0] pressed_events;
    logic [BUTTON_COUNT-1:0] released_events;
    logic                    any_event;

    modport master (
        output buttons_in,
        output frame_ack,
        input  buttons_stable,
        input  pressed_events,
        input  released_events,
        input  any_event
    );

    modport slave (
        input  buttons_in,
        input  frame_ack,
        output buttons_stable,
        output pressed_events,
        output released_events,
        output any_event
    );
endinterface

// File: rtl/button_debouncer.sv
// Per-button synchronizer plus stability counter; accepted level changes are latched
// as sticky press/release flags until the consumer acknowledges a frame.
module button_debouncer #(
    parameter int BUTTON_COUNT    = 16,
    parameter int DEBOUNCE_CYCLES = 252000
) (
    input logic                system_clk,
    input logic                reset,
    button_debouncer_if.slave  bus
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [BUTTON_COUNT-1:0] sync1_q;
    logic [BUTTON_COUNT-1:0] sync2_q;
    logic [BUTTON_COUNT-1:0] stable_q;
    logic [BUTTON_COUNT-1:0] stable_d;
    logic [BUTTON_COUNT-1:0] pressed_q;
    logic [BUTTON_COUNT-1:0] pressed_d;
    logic [BUTTON_COUNT-1:0] released_q;
    logic [BUTTON_COUNT-1:0] released_d;
    logic [BUTTON_COUNT-1:0] rise;
    logic [BUTTON_COUNT-1:0] fall;
    logic [CNT_W-1:0]        cnt_q [BUTTON_COUNT];
    logic [CNT_W-1:0]        cnt_d [BUTTON_COUNT];
    logic                    any_event_q;

    // The counter runs only while the synchronized level disagrees with the accepted
    // level; any agreement, or acceptance itself, restarts it from zero.
    always_comb begin
        stable_d = stable_q;
        rise     = '0;
        fall     = '0;
        for (int i = 0; i < BUTTON_COUNT; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                    rise[i]     = sync2_q[i];
                    fall[i]     = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        // An ack replaces the flags with this cycle's edges so coincident edges survive.
        pressed_d  = bus.frame_ack ? rise : (pressed_q | rise);
        released_d = bus.frame_ack ? fall : (released_q | fall);
    end

    always_ff @(posedge system_clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            pressed_q   <= '0;
            released_q  <= '0;
            any_event_q <= 1'b0;
            for (int i = 0; i < BUTTON_COUNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= bus.buttons_in;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            pressed_q   <= pressed_d;
            released_q  <= released_d;
            any_event_q <= |(pressed_q | released_q);
            for (int i = 0; i < BUTTON_COUNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.buttons_stable  = stable_q;
    assign bus.pressed_events  = pressed_q;
    assign bus.released_events = released_q;
    assign bus.any_event       = any_event_q;
endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios with literal
// expectations, then randomized buttons/acks/resets against a behavioural model.
module tb_button_debouncer;
    localparam int BC = 16;
    localparam int D  = 4;

    logic system_clk = 1'b0;
    logic reset      = 1'b1;

    button_debouncer_if #(.BUTTON_COUNT(BC)) bus ();

    button_debouncer #(
        .BUTTON_COUNT   (BC),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .system_clk(system_clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 system_clk = ~system_clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: accepted level, sticky flags, and for each button the
    // last edge at which its synchronized input agreed with (or was accepted into) it.
    logic [BC-1:0] mStable;
    logic [BC-1:0] mPressed;
    logic [BC-1:0] mReleased;
    logic          mAny;
    logic [BC-1:0] mVis;
    logic [BC-1:0] mNew;
    logic [BC-1:0] mRise;
    logic [BC-1:0] mFall;
    logic [BC-1:0] hist[$];
    int            lastOk[BC];
    int            edgeNo;
    bit            modelValid = 1'b0;
    logic [BC-1:0] nb;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [BC-1:0] btn, input logic ack);
        bus.buttons_in = btn;
        bus.frame_ack  = ack;
    endtask

    task automatic stepEdge(input int n);
        repeat (n) begin
            @(posedge system_clk);
            #1;
        end
    endtask

    // The input seen by the debounce rule in the cycle before edge n is the value
    // sampled two edges earlier; a level is accepted once it has disagreed for D cycles.
    initial forever begin
        @(posedge system_clk);
        if (reset) begin
            mStable   = '0;
            mPressed  = '0;
            mReleased = '0;
            mAny      = 1'b0;
            hist.delete();
            edgeNo    = 0;
            for (int i = 0; i < BC; i++) lastOk[i] = 0;
            modelValid = 1'b1;
        end else begin
            edgeNo++;
            mVis = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
            mNew = mStable;
            for (int i = 0; i < BC; i++) begin
                if (mVis[i] == mStable[i]) begin
                    lastOk[i] = edgeNo;
                end else if (edgeNo - lastOk[i] >= D) begin
                    mNew[i]   = mVis[i];
                    lastOk[i] = edgeNo;
                end
            end
            mRise     = mNew & ~mStable;
            mFall     = ~mNew & mStable;
            mAny      = |(mPressed | mReleased);
            mPressed  = bus.frame_ack ? mRise : (mPressed | mRise);
            mReleased = bus.frame_ack ? mFall : (mReleased | mFall);
            mStable   = mNew;
            hist.push_back(bus.buttons_in);
            if (hist.size() > 2) void'(hist.pop_front());
        end
    end

    initial forever begin
        @(negedge system_clk);
        if (modelValid) begin
            checkOutput("model_stable",   32'(bus.buttons_stable),  32'(mStable));
            checkOutput("model_pressed",  32'(bus.pressed_events),  32'(mPressed));
            checkOutput("model_released", 32'(bus.released_events), 32'(mReleased));
            checkOutput("model_any",      32'(bus.any_event),       32'(mAny));
        end
    end

    initial begin
        applyStimulus('0, 1'b0);
        reset = 1'b1;
        stepEdge(3);
        checkOutput("reset_stable",   32'(bus.buttons_stable),  32'h0);
        checkOutput("reset_pressed",  32'(bus.pressed_events),  32'h0);
        checkOutput("reset_released", 32'(bus.released_events), 32'h0);
        checkOutput("reset_any",      32'(bus.any_event),       32'h0);
        reset = 1'b0;
        stepEdge(3);

        // Press on bit 0: accepted exactly six edges after the change is presented.
        applyStimulus(16'h0001, 1'b0);
        stepEdge(5);
        checkOutput("press_e5_stable",  32'(bus.buttons_stable), 32'h0);
        checkOutput("press_e5_pressed", 32'(bus.pressed_events), 32'h0);
        stepEdge(1);
        checkOutput("press_e6_stable",  32'(bus.buttons_stable), 32'h1);
        checkOutput("press_e6_pressed", 32'(bus.pressed_events), 32'h1);
        checkOutput("press_e6_any",     32'(bus.any_event),      32'h0);
        stepEdge(1);
        checkOutput("press_e7_any",     32'(bus.any_event),      32'h1);
        applyStimulus(16'h0001, 1'b1);
        stepEdge(1);
        applyStimulus(16'h0001, 1'b0);
        checkOutput("ack_pressed", 32'(bus.pressed_events), 32'h0);
        checkOutput("ack_any_lag", 32'(bus.any_event),      32'h1);
        stepEdge(1);
        checkOutput("ack_any_clear", 32'(bus.any_event), 32'h0);

        // Three-cycle glitch on bit 3 must be rejected.
        applyStimulus(16'h0009, 1'b0);
        stepEdge(3);
        applyStimulus(16'h0001, 1'b0);
        stepEdge(8);
        checkOutput("glitch_stable",   32'(bus.buttons_stable),  32'h1);
        checkOutput("glitch_pressed",  32'(bus.pressed_events),  32'h0);
        checkOutput("glitch_released", 32'(bus.released_events), 32'h0);

        // Release of bit 0, re-press, then bit 1 rising in the ack cycle.
        applyStimulus(16'h0000, 1'b0);
        stepEdge(5);
        checkOutput("release_e5", 32'(bus.released_events), 32'h0);
        stepEdge(1);
        checkOutput("release_e6",        32'(bus.released_events), 32'h1);
        checkOutput("release_e6_stable", 32'(bus.buttons_stable),  32'h0);
        applyStimulus(16'h0001, 1'b0);
        stepEdge(1);
        applyStimulus(16'h0003, 1'b0);
        stepEdge(5);
        checkOutput("both_pressed",  32'(bus.pressed_events),  32'h1);
        checkOutput("both_released", 32'(bus.released_events), 32'h1);
        applyStimulus(16'h0003, 1'b1);
        stepEdge(1);
        applyStimulus(16'h0003, 1'b0);
        checkOutput("ackrise_pressed",  32'(bus.pressed_events),  32'h2);
        checkOutput("ackrise_released", 32'(bus.released_events), 32'h0);
        checkOutput("ackrise_stable",   32'(bus.buttons_stable),  32'h3);

        // Ack held for three cycles acts as repeated acks.
        applyStimulus(16'h0003, 1'b1);
        stepEdge(3);
        applyStimulus(16'h0003, 1'b0);
        checkOutput("longack_pressed",  32'(bus.pressed_events),  32'h0);
        checkOutput("longack_released", 32'(bus.released_events), 32'h0);
        checkOutput("longack_any",      32'(bus.any_event),       32'h0);

        // Eight-cycle pulse on bit 2 leaves both flags set.
        applyStimulus(16'h0007, 1'b0);
        stepEdge(8);
        applyStimulus(16'h0003, 1'b0);
        stepEdge(8);
        checkOutput("pulse_pressed",  32'(bus.pressed_events),  32'h4);
        checkOutput("pulse_released", 32'(bus.released_events), 32'h4);
        checkOutput("pulse_stable",   32'(bus.buttons_stable),  32'h3);

        // Reset while bit 4 is mid-debounce.
        applyStimulus(16'h0013, 1'b0);
        stepEdge(4);
        reset = 1'b1;
        stepEdge(2);
        checkOutput("midrst_stable",   32'(bus.buttons_stable),  32'h0);
        checkOutput("midrst_pressed",  32'(bus.pressed_events),  32'h0);
        checkOutput("midrst_released", 32'(bus.released_events), 32'h0);
        checkOutput("midrst_any",      32'(bus.any_event),       32'h0);
        reset = 1'b0;
        stepEdge(5);
        checkOutput("postrst_e5_stable", 32'(bus.buttons_stable), 32'h0);
        stepEdge(1);
        checkOutput("postrst_e6_stable",  32'(bus.buttons_stable), 32'h13);
        checkOutput("postrst_e6_pressed", 32'(bus.pressed_events), 32'h13);

        // All sixteen lines rise together.
        reset = 1'b1;
        applyStimulus(16'h0000, 1'b0);
        stepEdge(2);
        reset = 1'b0;
        stepEdge(3);
        applyStimulus(16'hFFFF, 1'b0);
        stepEdge(5);
        checkOutput("all_e5_stable", 32'(bus.buttons_stable), 32'h0);
        stepEdge(1);
        checkOutput("all_e6_stable",  32'(bus.buttons_stable), 32'hFFFF);
        checkOutput("all_e6_pressed", 32'(bus.pressed_events), 32'hFFFF);

        // Randomized phase: sporadic toggles (mix of glitches and accepted changes),
        // random acks and rare resets, all tracked by the model.
        for (int c = 0; c < 4000; c++) begin
            nb = bus.buttons_in;
            if ($urandom_range(0, 5) == 0) nb = nb ^ (16'($urandom) & 16'($urandom));
            reset = ($urandom_range(0, 599) == 0);
            applyStimulus(nb, $urandom_range(0, 7) == 0);
            stepEdge(1);
        end
        reset = 1'b0;
        applyStimulus(bus.buttons_in, 1'b0);
        stepEdge(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
